// File: rtl/note_recorder_pkg.sv
// Shared types and encodings for the note recorder: note codes, record
// field widths, the packed record layout consumed by the Sound driver,
// and the recorder state machine states.
package note_recorder_pkg;

    localparam int OCT_W  = 3;
    localparam int NOTE_W = 3;
    localparam int LEN_W  = 4;
    localparam int REC_W  = OCT_W + NOTE_W + LEN_W;

    localparam logic [LEN_W-1:0] LEN_MAX = 4'd15;

    typedef enum logic [NOTE_W-1:0] {
        NOTE_REST = 3'd0,
        NOTE_DO   = 3'd1,
        NOTE_RE   = 3'd2,
        NOTE_MI   = 3'd3,
        NOTE_FA   = 3'd4,
        NOTE_SOL  = 3'd5,
        NOTE_LA   = 3'd6,
        NOTE_SI   = 3'd7
    } note_e;

    typedef struct packed {
        logic [OCT_W-1:0]  octave;
        logic [NOTE_W-1:0] note;
        logic [LEN_W-1:0]  length;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_NOTE  = 3'd2,
        S_REST  = 3'd3,
        S_FULL  = 3'd4
    } state_e;

    // Lowest set key wins; no key pressed decodes to the rest code.
    function automatic logic [NOTE_W-1:0] decode_key(input logic [6:0] keys);
        logic [NOTE_W-1:0] n;
        n = NOTE_REST;
        for (int i = 6; i >= 0; i--) begin
            if (keys[i]) n = NOTE_W'(i + 1);
        end
        return n;
    endfunction

    // One-hot LED pattern for a note code; the rest code lights nothing.
    function automatic logic [6:0] note_onehot(input logic [NOTE_W-1:0] n);
        logic [6:0] oh;
        oh = '0;
        if (n != NOTE_REST) oh = 7'd1 << (n - 3'd1);
        return oh;
    endfunction

endpackage

// File: rtl/note_recorder_tempo_tick.sv
// Tempo prescaler: counts clk cycles and strobes tick once every
// TICK_CYCLES cycles. restart zeroes the count so a new segment starts
// a fresh tick period on its opening edge.
module tempo_tick #(
    parameter int TICK_CYCLES = 6250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic [PW-1:0] presc;

    // The tick of the final count belongs to whatever segment is closing,
    // so it is not suppressed by a simultaneous restart.
    assign tick = (presc == PRESC_LAST);

    // Free-running prescaler, wrapped on the last count or restarted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (restart || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/note_recorder.sv
// Note recorder: samples the note keys and octave while rec_en is high,
// times every held note or rest in tempo ticks, packs each segment into a
// {octave, note, length} record and stores it in a buffer that the
// playback path reads back through a registered port.
module note_recorder
    import note_recorder_pkg::*;
#(
    parameter int TICK_CYCLES = 6250000,
    parameter int DEPTH       = 64,
    parameter int AW          = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rec_en,
    input  logic [6:0]         key,
    input  logic [2:0]         octave,
    input  logic [AW-1:0]      rd_addr,
    output logic [REC_W-1:0]   rd_data,
    output logic [AW:0]        song_len,
    output logic               recording,
    output logic               full,
    output logic               overflow,
    output logic [6:0]         led,
    output logic [2:0]         cur_octave,
    output logic [2:0]         cur_note
);

    localparam logic [AW:0] LEN_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] LEN_DEPTH = (AW+1)'(DEPTH);

    state_e            state, state_n;
    logic [NOTE_W-1:0] seg_note, seg_note_n, dec_note;
    logic [OCT_W-1:0]  seg_oct, seg_oct_n;
    logic [LEN_W-1:0]  seg_len, seg_len_n, len_next;
    logic [AW:0]       song_len_n;
    logic              ovf, ovf_n;
    logic              tick, restart, wr_en, changed, sat, at_last;
    rec_t              wr_rec;
    rec_t              mem [DEPTH];
    rec_t              rd_q;

    // A record never has zero length: a segment shorter than one tick
    // still counts as one unit.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len == '0) ? LEN_W'(1) : len;
    endfunction

    tempo_tick #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    assign dec_note = decode_key(key);
    assign changed  = (dec_note != seg_note) || (octave != seg_oct);
    assign len_next = seg_len + {{(LEN_W-1){1'b0}}, tick};
    assign sat      = tick && (seg_len == LEN_MAX - LEN_W'(1));
    assign at_last  = (song_len == LEN_LAST);

    // Next-state, segment bookkeeping and record write control.
    always_comb begin
        state_n    = state;
        seg_note_n = seg_note;
        seg_oct_n  = seg_oct;
        seg_len_n  = len_next;
        song_len_n = song_len;
        ovf_n      = ovf;
        restart    = 1'b0;
        wr_en      = 1'b0;
        wr_rec     = '{octave: seg_oct, note: seg_note, length: clamp_len(len_next)};

        unique case (state)
            S_IDLE: begin
                if (rec_en) begin
                    song_len_n = '0;
                    ovf_n      = 1'b0;
                    state_n    = S_ARMED;
                end
            end

            S_ARMED: begin
                if (!rec_en) begin
                    state_n = S_IDLE;
                end else if (dec_note != NOTE_REST) begin
                    seg_note_n = dec_note;
                    seg_oct_n  = octave;
                    seg_len_n  = '0;
                    restart    = 1'b1;
                    state_n    = S_NOTE;
                end
            end

            S_NOTE, S_REST: begin
                if (!rec_en) begin
                    // A trailing rest carries no information and is dropped.
                    wr_en   = (state == S_NOTE);
                    state_n = S_IDLE;
                end else if (changed) begin
                    wr_en      = 1'b1;
                    seg_note_n = dec_note;
                    seg_oct_n  = octave;
                    seg_len_n  = '0;
                    restart    = 1'b1;
                    if (at_last)
                        state_n = S_FULL;
                    else
                        state_n = (dec_note == NOTE_REST) ? S_REST : S_NOTE;
                end else if (sat) begin
                    wr_en     = 1'b1;
                    wr_rec    = '{octave: seg_oct, note: seg_note, length: LEN_MAX};
                    seg_len_n = '0;
                    if (at_last) state_n = S_FULL;
                end
            end

            S_FULL: begin
                // Segments are still tracked so that every record that
                // would have been written is flagged as lost.
                if (!rec_en) begin
                    state_n = S_IDLE;
                end else if (changed) begin
                    ovf_n      = 1'b1;
                    seg_note_n = dec_note;
                    seg_oct_n  = octave;
                    seg_len_n  = '0;
                    restart    = 1'b1;
                end else if (sat) begin
                    ovf_n     = 1'b1;
                    seg_len_n = '0;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (wr_en) song_len_n = song_len + (AW+1)'(1);
    end

    // Control and segment registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            seg_note <= '0;
            seg_oct  <= '0;
            seg_len  <= '0;
            song_len <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_n;
            seg_note <= seg_note_n;
            seg_oct  <= seg_oct_n;
            seg_len  <= seg_len_n;
            song_len <= song_len_n;
            ovf      <= ovf_n;
        end
    end

    // Record buffer write port, addressed by the current record count.
    always_ff @(posedge clk) begin
        if (wr_en) mem[song_len[AW-1:0]] <= wr_rec;
    end

    // Registered playback read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= mem[rd_addr];
    end

    assign rd_data    = rd_q;
    assign overflow   = ovf;
    assign full       = (song_len == LEN_DEPTH);
    assign recording  = (state == S_ARMED) || (state == S_NOTE) || (state == S_REST);
    assign led        = (state == S_NOTE) ? note_onehot(seg_note) : '0;
    assign cur_note   = (state == S_NOTE) ? seg_note : '0;
    assign cur_octave = (state == S_NOTE) ? seg_oct  : '0;

endmodule

// File: doc/note_recorder.md
Name: note_recorder

Overview:
- Record-mode counterpart to the automatic player: writes songs rather than replaying them.
- Samples the seven note keys and the octave selector while recording is enabled, and measures each held note or rest in tempo ticks.
- Packs each segment into a {octave, note, length} record, using the same field encoding the Sound driver consumes.
- Stores records in an internal buffer; the playback path reads them back through a registered read port.

Parameters:
- TICK_CYCLES, 6250000, clk cycles per length unit (one tick); minimum 2.
- DEPTH, 64, record buffer entries.
- AW, 6, buffer address width; must equal clog2(DEPTH).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rec_en  in  1  level: 1 = record, 0 = stop or idle.
- key  in  7  note keys, already debounced and synchronous; bit i = note i+1.
- octave  in  3  current octave selector.
- rd_addr  in  AW  playback read address.
- rd_data  out  10  record at rd_addr, packed {octave[9:7], note[6:4], length[3:0]}.
- song_len  out  AW+1  number of valid records.
- recording  out  1  high in ARMED, NOTE or REST.
- full  out  1  buffer holds DEPTH records.
- overflow  out  1  sticky: a record was dropped.
- led  out  7  one-hot of the note currently being timed; 0 when none.
- cur_octave  out  3  live monitor for the Sound driver.
- cur_note  out  3  live monitor for the Sound driver.

Behaviour:
- Reset (async, any state, including mid-record):
  - State goes to IDLE.
  - All outputs are 0 and the pointer/count is 0.
  - Buffer contents are don't-care.
- Key decode: the lowest set bit wins (key=0000110 gives note 2); key=0 gives note 0, which encodes a rest.
- States:
  - IDLE: when rec_en=1, clear song_len and overflow, then go to ARMED.
  - ARMED: wait for key≠0. Leading rest is never recorded. On key≠0, open a NOTE segment.
  - NOTE / REST: timing a segment of the current (note, octave).
  - FULL: buffer full; no writes; stay until rec_en=0.
- Segment timing:
  - On the opening edge, presc=0 and seg_len=0.
  - presc increments every cycle. When presc==TICK_CYCLES-1 it wraps to 0 and seg_len increments.
  - A segment held exactly N·TICK_CYCLES cycles therefore yields length N.
- Segment close: triggered in any cycle where the decoded (note, octave) differs from the open segment.
  - The record is written at that clock edge with length = max(seg_len,1).
  - The new segment opens at the same edge: a REST segment if key=0, otherwise NOTE.
  - A tick in the same cycle is counted into the closing segment first.
- Saturation: when a tick takes seg_len to 15, a record of length 15 is written at that edge. The segment restarts with the same note and seg_len=0.
- Writes: at most one record per cycle, to address song_len, which then increments.
  - When song_len reaches DEPTH, go to FULL and assert full.
  - Any further close or saturation write is dropped and sets overflow, which stays set until the next IDLE→ARMED.
- Stop: rec_en=0 while in NOTE flushes the open segment (length max(seg_len,1)) on that edge.
  - A trailing REST is discarded.
  - ARMED or FULL go to IDLE. song_len, full and overflow hold.
- Read port: rd_data is registered with 1-cycle latency and valid in every state. Reads of addresses ≥ song_len return stale data.
- led, cur_note and cur_octave show the open NOTE segment; they are 0 in other states.

Decomposition:
- Shared package contains:
  - note codes (REST=0, DO=1 … SI=7);
  - field widths OCT_W=3, NOTE_W=3, LEN_W=4;
  - LEN_MAX=15;
  - packed record typedef;
  - state enum.
- One sub-module, tempo_tick: the prescaler with a synchronous restart input and a tick strobe output.

Test Plan (TICK_CYCLES=4, DEPTH=4):
- Basic record:
  - Stimulus: rec_en=1, octave=4; key=0000100 for 12 cycles, key=0 for 8 cycles, key=0010000 for 2 cycles, then rec_en=0.
  - Required: records {4,3,3}, {4,0,2}, {4,5,1}; song_len=3. Also a leading 5-cycle key=0 before the first note records nothing.
- Saturation: hold key=0000001 for 64 cycles, then stop → records {oct,1,15} then {oct,1,1}; song_len=2.
- Octave change mid-note: note 2 held for 8 cycles at octave 3, then octave changes to 5 for 4 cycles → records {3,2,2}, {5,2,1}.
- Overflow: produce 6 segments → full=1 after the 4th write, overflow=1, song_len=4, and the buffer keeps the first 4 records. A new rec_en rise clears overflow and song_len.
- Reset and readback:
  - rst_n low mid-NOTE → all outputs 0 immediately, without waiting for a clock edge.
  - After a recording, drive rd_addr=1 → rd_data equals record 1 on the next cycle.
- Key priority: key=0000110 → led=0000010, cur_note=2.
